// File: rtl/shift_packer.sv
// shift_packer: gathers RATIO beats of IN_W bits into one OUT_W word with flush of partial words.
// Optional feature: define SHIFT_PACKER_PARITY_EN to add the out_parity port (per-lane even parity).
module shift_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [IN_W*RATIO-1:0]        out_data,
    output logic                         out_valid,
`ifdef SHIFT_PACKER_PARITY_EN
    output logic [RATIO-1:0]             out_parity,
`endif
    output logic [$clog2(RATIO+1)-1:0]   out_count,
    input  logic                         out_ready
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d, acc_next_s;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d, lane_s, fill_s;
    logic             out_valid_q, out_valid_d;
    logic             out_free_s, in_ready_s, beat_s, emit_s;

`ifdef SHIFT_PACKER_PARITY_EN
    logic [RATIO-1:0] out_parity_q, out_parity_d;

    function automatic logic [RATIO-1:0] lane_parity(input logic [OUT_W-1:0] word);
        logic [RATIO-1:0] p;
        for (int j = 0; j < RATIO; j++) begin
            p[j] = ^word[j*IN_W +: IN_W];
        end
        return p;
    endfunction
`endif

    // Handshake, lane placement and emit decision for this cycle.
    always_comb begin
        out_free_s = !out_valid_q || out_ready;
        // The last lane may only be filled when the output register can take the word.
        in_ready_s = out_free_s || (cnt_q < LAST_LANE);
        beat_s     = in_valid && in_ready_s;
        lane_s     = (MSB_FIRST != 0) ? (LAST_LANE - cnt_q) : cnt_q;
        for (int j = 0; j < RATIO; j++) begin
            acc_next_s[j*IN_W +: IN_W] = (beat_s && (lane_s == CNT_W'(j))) ? in_data
                                                                          : acc_q[j*IN_W +: IN_W];
        end
        fill_s = cnt_q + CNT_W'(beat_s);
        emit_s = (beat_s && (cnt_q == LAST_LANE)) ||
                 (flush && out_free_s && (fill_s != {CNT_W{1'b0}}));
    end

    // Next-state for accumulator, lane count and output register.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        if (emit_s) begin
            out_data_d  = acc_next_s;
            out_count_d = fill_s;
            out_valid_d = 1'b1;
            acc_d       = {OUT_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
        end else begin
            acc_d       = acc_next_s;
            cnt_d       = fill_s;
            out_valid_d = out_valid_q && !out_ready;
        end
    end

`ifdef SHIFT_PACKER_PARITY_EN
    // Parity is captured together with the word it describes.
    always_comb begin
        if (emit_s) begin
            out_parity_d = lane_parity(acc_next_s);
        end else begin
            out_parity_d = out_parity_q;
        end
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            acc_q        <= {OUT_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            out_data_q   <= {OUT_W{1'b0}};
            out_count_q  <= {CNT_W{1'b0}};
            out_valid_q  <= 1'b0;
`ifdef SHIFT_PACKER_PARITY_EN
            out_parity_q <= {RATIO{1'b0}};
`endif
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_valid_q  <= out_valid_d;
`ifdef SHIFT_PACKER_PARITY_EN
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign in_ready   = in_ready_s;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign out_valid  = out_valid_q;
`ifdef SHIFT_PACKER_PARITY_EN
    assign out_parity = out_parity_q;
`endif

endmodule
